// File: rtl/lfsr_gen_if.sv
// Parallel/serial LFSR generator bus: step/load controls in, state, serial bit,
// wrap pulse, measured period and lock-up flag out.
interface lfsr_gen_if #(
    parameter int unsigned WIDTH = 11
) ();
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] q;
    logic             bit_out;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             lockup;

    modport master (
        output en, load, seed_in,
        input  q, bit_out, wrap, period, lockup
    );

    modport slave (
        input  en, load, seed_in,
        output q, bit_out, wrap, period, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with step enable, seed load, period measurement and lock-up flag.
// Define LFSR_LOCKUP_RECOVER_EN to recover automatically from the all-zero state.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 11,
    parameter logic [WIDTH-1:0] TAPS  = 11'h500,
    parameter logic [WIDTH-1:0] SEED  = 11'h001
) (
    input  logic      clk,
    input  logic      rst,
    lfsr_gen_if.slave bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             fb;
    logic [WIDTH-1:0] q_step;
    logic             q_zero;
`ifdef LFSR_LOCKUP_RECOVER_EN
    logic             zload_q, zload_d;
`endif

    always_comb begin
        fb       = ^(q_q & TAPS);
        q_step   = {q_q[WIDTH-2:0], fb};
        q_zero   = (q_q == '0);

        q_d      = q_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        zload_d  = 1'b0;
`endif

        if (bus.load) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            // A zero seed would lock the register; substitute SEED and flag it once.
            if (bus.seed_in == '0) begin
                q_d     = SEED;
                ref_d   = SEED;
                zload_d = 1'b1;
            end else begin
                q_d     = bus.seed_in;
                ref_d   = bus.seed_in;
            end
`else
            q_d   = bus.seed_in;
            ref_d = bus.seed_in;
`endif
            cnt_d = '0;
        end else if (bus.en) begin
            if (!q_zero) begin
                q_d = q_step;
                if (q_step == ref_q) begin
                    wrap_d   = 1'b1;
                    period_d = cnt_q + WIDTH'(1);
                    cnt_d    = '0;
                end else begin
                    cnt_d    = cnt_q + WIDTH'(1);
                end
            end
`ifdef LFSR_LOCKUP_RECOVER_EN
            else begin
                q_d   = SEED;
                ref_d = SEED;
                cnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= SEED;
            ref_q    <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
            zload_q  <= 1'b0;
`endif
        end else begin
            q_q      <= q_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
`ifdef LFSR_LOCKUP_RECOVER_EN
            zload_q  <= zload_d;
`endif
        end
    end

    assign bus.q       = q_q;
    assign bus.bit_out = q_q[WIDTH-1];
    assign bus.wrap    = wrap_q;
    assign bus.period  = period_q;
`ifdef LFSR_LOCKUP_RECOVER_EN
    assign bus.lockup  = q_zero | zload_q;
`else
    assign bus.lockup  = q_zero;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: vector table for the first steps, scoreboard-checked runs
// for period, load, hold, zero-load and reset cases, plus a 4-bit instance.
module tb_lfsr_gen;

    typedef struct {
        logic        rst;
        logic        load;
        logic        en;
        logic [10:0] seed;
        logic [10:0] q;
        logic        bo;
        logic        wrap;
        logic [10:0] period;
        logic        lock;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(11)) bus ();
    lfsr_gen_if #(.WIDTH(4))  sbus ();

    lfsr_gen #(.WIDTH(11), .TAPS(11'h500), .SEED(11'h001)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut_s (
        .clk(clk), .rst(rst_s), .bus(sbus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    vec_t sb[$];
    vec_t tbl[12];
    vec_t none;

    logic [10:0] m_q, m_ref, m_cnt, m_per;
    logic        m_wrap, m_zl;

    int unsigned wraps, wrap_at, lock_hi;
    logic [10:0] wrap_qv;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        cmp(name, act, exp);
    endtask

    task automatic model_step(input logic r, input logic l, input logic e, input logic [10:0] s);
        logic [10:0] nx;
        m_wrap = 1'b0;
        m_zl   = 1'b0;
        if (r) begin
            m_q = 11'h001; m_ref = 11'h001; m_cnt = '0; m_per = '0;
        end else if (l) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (s == 11'h0) begin
                m_q = 11'h001; m_ref = 11'h001; m_zl = 1'b1;
            end else begin
                m_q = s; m_ref = s;
            end
`else
            m_q = s; m_ref = s;
`endif
            m_cnt = '0;
        end else if (e) begin
            if (m_q == 11'h0) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
                m_q = 11'h001; m_ref = 11'h001; m_cnt = '0;
`endif
            end else begin
                nx    = {m_q[9:0], m_q[10] ^ m_q[8]};
                m_cnt = m_cnt + 11'd1;
                m_q   = nx;
                if (nx == m_ref) begin
                    m_wrap = 1'b1;
                    m_per  = m_cnt;
                    m_cnt  = '0;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic [10:0] s,
                         input logic use_tbl, input vec_t tv);
        vec_t ex;
        @(negedge clk);
        rst         = r;
        bus.load    = l;
        bus.en      = e;
        bus.seed_in = s;
        model_step(r, l, e, s);
        if (use_tbl) ex = tv;
        else begin
            ex.rst = r; ex.load = l; ex.en = e; ex.seed = s;
            ex.q = m_q; ex.bo = m_q[10]; ex.wrap = m_wrap; ex.period = m_per;
            ex.lock = (m_q == 11'h0) | m_zl;
        end
        sb.push_back(ex);
        @(posedge clk);
        #1;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            ex = sb.pop_front();
            cmp("q", 32'(bus.q), 32'(ex.q));
            cmp("bit_out", 32'(bus.bit_out), 32'(ex.bo));
            cmp("wrap", 32'(bus.wrap), 32'(ex.wrap));
            cmp("period", 32'(bus.period), 32'(ex.period));
            cmp("lockup", 32'(bus.lockup), 32'(ex.lock));
        end
        if (bus.wrap) begin
            wraps++;
            wrap_qv = bus.q;
        end
        if (bus.lockup) lock_hi++;
    endtask

    task automatic run(input int unsigned n, input logic e);
        wraps = 0; wrap_at = 0; lock_hi = 0; wrap_qv = '0;
        for (int unsigned i = 1; i <= n; i++) begin
            drive(1'b0, 1'b0, e, 11'h0, 1'b0, none);
            if (bus.wrap) wrap_at = i;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] q0;
        logic        l0;
        int unsigned s_wraps;

        bus.en = 1'b0; bus.load = 1'b0; bus.seed_in = '0;
        sbus.en = 1'b0; sbus.load = 1'b0; sbus.seed_in = '0;
        none = '{1'b0, 1'b0, 1'b0, 11'h0, 11'h0, 1'b0, 1'b0, 11'h0, 1'b0};

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 11'h000, 11'h001, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h002, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h004, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h008, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h010, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h020, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h040, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h080, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h100, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h201, 1'b0, 1'b0, 11'h0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h402, 1'b1, 1'b0, 11'h0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 11'h000, 11'h005, 1'b0, 1'b0, 11'h0, 1'b0};

        for (int unsigned i = 0; i < 12; i++)
            drive(tbl[i].rst, tbl[i].load, tbl[i].en, tbl[i].seed, 1'b1, tbl[i]);

        // Full period from reset
        drive(1'b1, 1'b0, 1'b0, 11'h0, 1'b0, none);
        run(2047, 1'b1);
        chk("fp_wraps", wraps, 1);
        chk("fp_wrap_step", wrap_at, 2047);
        chk("fp_wrap_q", 32'(wrap_qv), 32'h001);
        chk("fp_period", 32'(bus.period), 2047);

        // Load beats enable, then a full period back to the loaded value
        run(100, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 11'h7FF, 1'b0, none);
        chk("ld_q", 32'(bus.q), 32'h7FF);
        run(2047, 1'b1);
        chk("ld_wraps", wraps, 1);
        chk("ld_wrap_step", wrap_at, 2047);
        chk("ld_wrap_q", 32'(wrap_qv), 32'h7FF);

        // Hold at 0x201
        drive(1'b0, 1'b1, 1'b0, 11'h201, 1'b0, none);
        run(10, 1'b0);
        chk("hold_q", 32'(bus.q), 32'h201);
        chk("hold_wraps", wraps, 0);
        chk("hold_period", 32'(bus.period), 2047);

        // Zero seed load
        drive(1'b0, 1'b1, 1'b0, 11'h0, 1'b0, none);
        q0 = bus.q;
        l0 = bus.lockup;
        run(5, 1'b1);
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("zl_q_after_load", 32'(q0), 32'h001);
        chk("zl_lock_pulse", 32'(l0), 1);
        chk("zl_lock_after", lock_hi, 0);
        chk("zl_q_final", 32'(bus.q), 32'h020);
`else
        chk("zl_q_after_load", 32'(q0), 32'h000);
        chk("zl_lock_pulse", 32'(l0), 1);
        chk("zl_lock_after", lock_hi, 5);
        chk("zl_wraps", wraps, 0);
        chk("zl_q_final", 32'(bus.q), 32'h000);
`endif

        // Reset aborts a measurement in progress
        drive(1'b0, 1'b1, 1'b0, 11'h001, 1'b0, none);
        run(2047, 1'b1);
        chk("rm_period_before", 32'(bus.period), 2047);
        run(500, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 11'h0, 1'b0, none);
        chk("rm_q", 32'(bus.q), 32'h001);
        chk("rm_period", 32'(bus.period), 0);
        chk("rm_wrap", 32'(bus.wrap), 0);
        run(2047, 1'b1);
        chk("rm_wraps", wraps, 1);
        chk("rm_period_after", 32'(bus.period), 2047);

        // 4-bit instance, x^4+x^3+1
        @(negedge clk);
        rst_s = 1'b1;
        @(posedge clk);
        #1;
        chk("s_reset_q", 32'(sbus.q), 32'h1);
        chk("s_reset_period", 32'(sbus.period), 0);
        s_wraps = 0;
        for (int unsigned i = 1; i <= 30; i++) begin
            @(negedge clk);
            rst_s   = 1'b0;
            sbus.en = 1'b1;
            @(posedge clk);
            #1;
            if (sbus.wrap) begin
                s_wraps++;
                chk("s_wrap_step", i % 15, 0);
                chk("s_wrap_q", 32'(sbus.q), 32'h1);
                chk("s_period", 32'(sbus.period), 15);
            end
        end
        chk("s_wraps", s_wraps, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random sequence generator with configurable width, tap mask and reset seed. It adds a step enable, synchronous seed load, period measurement and all-zero lock-up detection. Within the test-pattern and scrambler datapath, it is the configurable generator and drives both a parallel state word and a serial bit stream.

## Interface
Parameters:
- `WIDTH`, 11: state width in bits; legal range 3–32.
- `TAPS`, 11'h500: feedback tap mask; bit i set means `q[i]` enters the feedback XOR. The default is x^11+x^9+1, which is maximal length with period 2047.
- `SEED`, 11'h001: reset value and lock-up recovery value; must be non-zero.

Ports:
- `clk`, in, 1: clock; all logic is rising-edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `en`, in, 1: advance the LFSR one step this cycle.
- `load`, in, 1: load `seed_in` this cycle.
- `seed_in`, in, WIDTH: value to load.
- `q`, out, WIDTH: current LFSR state, registered.
- `bit_out`, out, 1: serial output, equal to `q[WIDTH-1]`.
- `wrap`, out, 1: one-cycle pulse when the state returns to the reference value.
- `period`, out, WIDTH: step count of the last completed cycle; 0 until the first wrap.
- `lockup`, out, 1: high whenever `q` is all-zero (see Configuration).

## Operation
- Step rule: `fb = ^(q & TAPS)`, then `q_next = {q[WIDTH-2:0], fb}`.
- Command priority is `rst` > `load` > `en`. When none are active, all state holds.
- `rst`: `q=SEED`, `ref=SEED`, `cnt=0`, `period=0`, `wrap=0`.
- `load`: `q=seed_in`, `ref=seed_in`, `cnt=0`, `wrap=0`. `period` is kept. `en` in the same cycle is ignored.
- `en`, with no load and `q` non-zero: `q=q_next` and `cnt=cnt+1`.
  - If `q_next==ref`, then `wrap` pulses, `period` is set to `cnt+1`, and `cnt` is set to 0.
- Internal reference register `ref` is WIDTH bits and holds the last loaded or reset value.
- Step counter `cnt` is WIDTH bits. It cannot overflow for any maximal or shorter sequence, since the period is at most 2^WIDTH−1.
  - A non-maximal `TAPS` value whose sequence never returns to `ref` leaves `period` unchanged. In that case `cnt` wraps modulo 2^WIDTH silently.
- All-zero state: `lockup` is high whenever `q==0`. Recovery behaviour is set by the macro; see Configuration.
- `wrap` is never asserted in a cycle without a step.

## Timing
- Every output is registered. The effect of `en`, `load` or `rst` is visible on `q` in the cycle after the sampling edge.
- `bit_out` and `lockup` are combinational decodes of the registered `q`. They have no extra latency.
- `wrap` and the updated `period` appear on the same edge as the `q` value that equals `ref`. `wrap` lasts exactly one cycle, even if `en` stays high.
- Reset values: `q=SEED`, `bit_out=SEED[WIDTH-1]`, `wrap=0`, `period=0`, `lockup=0`.
- Reset mid-run aborts the period measurement. The next measurement starts from `SEED`.
- When `en` is high continuously, `q` steps every cycle and there are no bubbles.

## Configuration
- Macro: `LFSR_LOCKUP_RECOVER_EN`.
- Defined:
  - A `load` with `seed_in==0` loads `SEED` into both `q` and `ref`. `lockup` pulses for one cycle in the cycle after the load.
  - If `q` is found to be 0 (for example from a tap mask that reaches 0), the next `en` cycle loads `SEED` instead of `q_next` and clears `cnt`.
- Undefined:
  - Zero is loaded as given. `q` remains 0 on every `en`, because the XOR of zeros is 0.
  - `lockup` stays high until the next `load` of a non-zero value or `rst`. `cnt` does not advance while `q==0`, and `wrap` never fires.

## Test plan
- Reset and first steps, defaults: reset, then `en` high.
  - Required sequence on `q`: 0x001, 0x002, 0x004, …, 0x100, 0x201, 0x402, 0x005.
  - `bit_out` rises on the first cycle where `q[10]` is set.
- Full period, defaults: `en` held high for 2047 cycles after reset. `wrap` pulses exactly once, with `q=0x001` and `period=2047`; there is no other pulse within the period.
- Load precedence: mid-run, `load=1`, `en=1`, `seed_in=0x7FF`.
  - Next cycle: `q=0x7FF`, no step, `cnt` cleared.
  - After a further 2047 steps: `wrap` with `q=0x7FF`.
- Hold: `en=0` for 10 cycles at `q=0x201`. `q` stays 0x201, `wrap` stays 0, and `period` is unchanged.
- Zero load, run both builds with `load=1`, `seed_in=0`, then `en` high for 5 cycles:
  - With the macro: `q=0x001` and a one-cycle `lockup` pulse.
  - Without the macro: `q=0`, `lockup` stays high, and `wrap` stays low.
- Reset mid-run and alternate parameters: assert `rst` after 500 steps.
  - `q=0x001`, `period=0`, `wrap=0` on the next cycle.
  - Repeat the full-period test with `WIDTH=4`, `TAPS=4'hC`, `SEED=4'h1`: `period=15`.
